// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
// Cycles a two-digit hex display through four sensor channels. Each channel
// is shown for DWELL_CYCLES clocks by writing its byte to the value-display
// PIO (HEX1_0) and a "C<n>" tag to the channel-display PIO (HEX5_4).
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         level, 1 = run the scan
//   freeze         level, 1 = stay on the current channel at dwell expiry
//   ch_data[31:0]  four sensor bytes, channel i in bits [8i+7:8i]
//   ch_valid[3:0]  one-cycle strobe per channel byte
//   pio_address    PIO slave address (always 0)
//   pio_cs_val     chipselect of the value-display PIO
//   pio_cs_ch      chipselect of the channel-display PIO
//   pio_write_n    active-low write strobe shared by both PIOs
//   pio_writedata  write word, only bits [13:0] used
//   cur_ch         channel currently shown
//   busy           1 whenever the scan FSM is not idle
module hex_scan_ctrl #(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        freeze,
    input  logic [31:0] ch_data,
    input  logic [3:0]  ch_valid,
    output logic [1:0]  pio_address,
    output logic        pio_cs_val,
    output logic        pio_cs_ch,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic [1:0]  cur_ch,
    output logic        busy
);

    localparam logic [25:0] DWELL_LAST = 26'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WR_VAL = 3'd2,
        ST_WR_CH  = 3'd3,
        ST_DWELL  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  cur_ch_s;
    logic [25:0] cnt_r;
    logic [25:0] cnt_s;
    logic        resume_r;
    logic        resume_s;
    logic [7:0]  shadow_r [4];
    logic [3:0]  seen_r;

    logic        cs_val_s;
    logic        cs_ch_s;
    logic        write_n_s;
    logic [31:0] writedata_s;
    logic [7:0]  sel_byte_s;
    logic        sel_seen_s;

    // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Per-channel shadow bytes and seen flags; all four lanes update independently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 8'h00;
            end
            seen_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (ch_valid[i]) begin
                    shadow_r[i] <= ch_data[8*i +: 8];
                    seen_r[i]   <= 1'b1;
                end
            end
        end
    end

    // Next-state, channel, dwell counter and refresh-resume logic.
    always_comb begin
        state_s  = state_r;
        cur_ch_s = cur_ch;
        cnt_s    = cnt_r;
        resume_s = resume_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_s = ST_WR_VAL;
            ST_WR_VAL: state_s = ST_WR_CH;
            ST_WR_CH: begin
                state_s  = ST_DWELL;
                resume_s = 1'b0;
                // A refresh keeps the remaining dwell time instead of restarting it.
                if (resume_r) begin
                    cnt_s = cnt_r;
                end else begin
                    cnt_s = DWELL_LAST;
                end
            end
            ST_DWELL: begin
                if (cnt_r == 26'd0) begin
                    if (!enable) begin
                        state_s = ST_IDLE;
                    end else if (freeze) begin
                        state_s = ST_LOAD;
                    end else begin
                        cur_ch_s = cur_ch + 2'd1;
                        state_s  = ST_LOAD;
                    end
                end else if (ch_valid[cur_ch]) begin
                    // The decremented count is what remains after this cycle.
                    cnt_s    = cnt_r - 26'd1;
                    resume_s = 1'b1;
                    state_s  = ST_LOAD;
                end else begin
                    cnt_s = cnt_r - 26'd1;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Bus word for the next cycle: outputs are registered, so the word is staged
    // one state early (LOAD stages the value write, WR_VAL stages the tag write).
    always_comb begin
        sel_byte_s  = shadow_r[cur_ch];
        sel_seen_s  = seen_r[cur_ch];
        cs_val_s    = 1'b0;
        cs_ch_s     = 1'b0;
        write_n_s   = 1'b1;
        writedata_s = 32'h0000_0000;
        case (state_r)
            ST_LOAD: begin
                cs_val_s  = 1'b1;
                write_n_s = 1'b0;
                if (sel_seen_s) begin
                    writedata_s = {18'd0, seg7(sel_byte_s[7:4]), seg7(sel_byte_s[3:0])};
                end else begin
                    writedata_s = {18'd0, 7'h3F, 7'h3F};
                end
            end
            ST_WR_VAL: begin
                cs_ch_s     = 1'b1;
                write_n_s   = 1'b0;
                writedata_s = {18'd0, 7'h46, seg7({2'b00, cur_ch})};
            end
            default: begin
                cs_val_s    = 1'b0;
                cs_ch_s     = 1'b0;
                write_n_s   = 1'b1;
                writedata_s = 32'h0000_0000;
            end
        endcase
    end

    // State, counter and registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cur_ch        <= 2'd0;
            cnt_r         <= 26'd0;
            resume_r      <= 1'b0;
            busy          <= 1'b0;
            pio_address   <= 2'd0;
            pio_cs_val    <= 1'b0;
            pio_cs_ch     <= 1'b0;
            pio_write_n   <= 1'b1;
            pio_writedata <= 32'h0000_0000;
        end else begin
            state_r       <= state_s;
            cur_ch        <= cur_ch_s;
            cnt_r         <= cnt_s;
            resume_r      <= resume_s;
            busy          <= (state_s != ST_IDLE);
            pio_address   <= 2'd0;
            pio_cs_val    <= cs_val_s;
            pio_cs_ch     <= cs_ch_s;
            pio_write_n   <= write_n_s;
            pio_writedata <= writedata_s;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Testbench for hex_scan_ctrl with DWELL_CYCLES=4. A slot-position reference
// model (cycles since LOAD, dwell length of the slot) predicts every bus cycle.
module tb_hex_scan_ctrl;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        freeze;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [1:0]  pio_address;
    logic        pio_cs_val;
    logic        pio_cs_ch;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [1:0]  cur_ch;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         m_active;
    int         m_t;
    int         m_len;
    logic [1:0] m_ch;
    logic [7:0] m_shadow [4];
    logic [3:0] m_seen;
    logic [7:0] m_snap_byte;
    bit         m_snap_seen;
    logic [6:0] seg_tab [16];

    hex_scan_ctrl #(.DWELL_CYCLES(DW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .freeze        (freeze),
        .ch_data       (ch_data),
        .ch_valid      (ch_valid),
        .pio_address   (pio_address),
        .pio_cs_val    (pio_cs_val),
        .pio_cs_ch     (pio_cs_ch),
        .pio_write_n   (pio_write_n),
        .pio_writedata (pio_writedata),
        .cur_ch        (cur_ch),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_t         = 0;
        m_len       = DW;
        m_ch        = 2'd0;
        m_seen      = 4'b0000;
        m_snap_byte = 8'h00;
        m_snap_seen = 1'b0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
    endtask

    // Advance the model by one clock, given the inputs present during this cycle.
    // m_t: 0 = LOAD slot, 1 = value write, 2 = channel write, 3.. = dwell cycles.
    task automatic model_step(input bit en, input bit frz, input logic [3:0] v, input logic [31:0] d);
        if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_t      = 0;
                m_len    = DW;
            end
        end else if (m_t == 0) begin
            m_snap_byte = m_shadow[m_ch];
            m_snap_seen = m_seen[m_ch];
            m_t         = 1;
        end else if (m_t < 3) begin
            m_t++;
        end else if (m_t == 2 + m_len) begin
            if (!en) begin
                m_active = 1'b0;
            end else begin
                if (!frz) m_ch = m_ch + 2'd1;
                m_t   = 0;
                m_len = DW;
            end
        end else if (v[m_ch]) begin
            m_len = m_len - (m_t - 3) - 1;
            m_t   = 0;
        end else begin
            m_t++;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                m_shadow[i] = d[8*i +: 8];
                m_seen[i]   = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        bit          e_val;
        bit          e_ch;
        logic [31:0] e_wd;
        e_val = m_active && (m_t == 1);
        e_ch  = m_active && (m_t == 2);
        e_wd  = 32'h0;
        if (e_val) begin
            if (m_snap_seen) e_wd = {18'd0, seg_tab[m_snap_byte[7:4]], seg_tab[m_snap_byte[3:0]]};
            else             e_wd = {18'd0, 7'h3F, 7'h3F};
        end
        if (e_ch) e_wd = {18'd0, 7'h46, seg_tab[{2'b00, m_ch}]};
        check_eq("cs_val",    32'(pio_cs_val), 32'(e_val));
        check_eq("cs_ch",     32'(pio_cs_ch), 32'(e_ch));
        check_eq("write_n",   32'(pio_write_n), 32'(!(e_val || e_ch)));
        check_eq("writedata", pio_writedata, e_wd);
        check_eq("address",   32'(pio_address), 32'h0);
        check_eq("cur_ch",    32'(cur_ch), 32'(m_ch));
        check_eq("busy",      32'(busy), 32'(m_active));
        check_eq("cs_excl",   32'(pio_cs_val & pio_cs_ch), 32'h0);
    endtask

    // Drive one cycle of inputs, advance model, then compare after the edge.
    task automatic rc(input bit en, input bit frz, input logic [3:0] v, input logic [31:0] d);
        enable   = en;
        freeze   = frz;
        ch_valid = v;
        ch_data  = d;
        model_step(en, frz, v, d);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset_n  = 1'b0;
        enable   = 1'b0;
        freeze   = 1'b0;
        ch_valid = 4'b0000;
        ch_data  = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_write_n", 32'(pio_write_n), 32'h1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        compare_all();

        // Dashes then C0, data for ch1 arrives during ch0 dwell
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("load0_ch", 32'(cur_ch), 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("dash_val", pio_writedata, 32'h1FBF);
        check_eq("dash_cs", 32'(pio_cs_val), 32'h1);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("c0_tag", pio_writedata, 32'h2340);
        rc(1'b1, 1'b0, 4'b0010, 32'h0000_3A00);
        repeat (3) rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("load1_ch", 32'(cur_ch), 32'h1);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("val_3A", pio_writedata, 32'h1808);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("c1_tag", pio_writedata, 32'h2379);

        // Remaining channels and wrap to 0
        for (int s = 2; s <= 4; s++) begin
            repeat (4) rc(1'b1, 1'b0, 4'b0000, 32'h0);
            rc(1'b1, 1'b0, 4'b0000, 32'h0);
            check_eq("wrap_seq", 32'(cur_ch), 32'(s % 4));
            repeat (2) rc(1'b1, 1'b0, 4'b0000, 32'h0);
        end

        // Freeze at expiry keeps channel 0
        repeat (4) rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b1, 4'b0000, 32'h0);
        check_eq("freeze_ch", 32'(cur_ch), 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("freeze_val", pio_writedata, 32'h1FBF);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);

        // Refresh with counter at 2
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b0, 4'b0001, 32'h0000_00A5);
        check_eq("refresh_busy", 32'(busy), 32'h1);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("refresh_val", pio_writedata, 32'h0412);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("refresh_tag", pio_writedata, 32'h2340);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("resume_quiet", 32'(pio_write_n), 32'h1);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("resume_next_ch", 32'(cur_ch), 32'h1);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("resume_val", pio_writedata, 32'h1808);

        // Enable dropped during WR_VAL
        rc(1'b0, 1'b0, 4'b0000, 32'h0);
        check_eq("drop_wr_ch", 32'(pio_cs_ch), 32'h1);
        repeat (4) rc(1'b0, 1'b0, 4'b0000, 32'h0);
        rc(1'b0, 1'b0, 4'b0000, 32'h0);
        check_eq("drop_idle_busy", 32'(busy), 32'h0);
        repeat (3) rc(1'b0, 1'b0, 4'b0000, 32'h0);

        // Reset during WR_CH
        repeat (3) rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("pre_rst_cs_ch", 32'(pio_cs_ch), 32'h1);
        pulse_reset();
        check_eq("rst_cs_ch", 32'(pio_cs_ch), 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        rc(1'b1, 1'b0, 4'b0000, 32'h0);
        check_eq("post_rst_val", pio_writedata, 32'h1FBF);
        check_eq("post_rst_ch", 32'(cur_ch), 32'h0);

        // Randomized run against the model
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] v;
            for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 7) == 0);
            rc($urandom_range(0, 19) != 0, $urandom_range(0, 4) == 0, v, $urandom);
            if ($urandom_range(0, 599) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000, meaning clk cycles each channel stays displayed; legal range 2..2^26-1.
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  level; 1 = run display scan.
REQ-005 SHALL have port freeze  input  1  level; 1 = hold current channel at dwell expiry.
REQ-006 SHALL have port ch_data  input  32  four sensor bytes; channel i = ch_data[8i+7:8i].
REQ-007 SHALL have port ch_valid  input  4  one-cycle strobe per channel; byte i is valid when bit i = 1.
REQ-008 SHALL have port pio_address  output  2  PIO slave address; always 0.
REQ-009 SHALL have port pio_cs_val  output  1  chipselect of value-display PIO (HEX1_0).
REQ-010 SHALL have port pio_cs_ch  output  1  chipselect of channel-display PIO (HEX5_4).
REQ-011 SHALL have port pio_write_n  output  1  active-low write strobe shared by both PIOs.
REQ-012 SHALL have port pio_writedata  output  32  write word; bits [31:14] always 0.
REQ-013 SHALL have port cur_ch  output  2  channel currently shown.
REQ-014 SHALL have port busy  output  1  1 in any state other than IDLE.

Function
REQ-015 SHALL hold a shadow byte and a seen flag per channel; a ch_valid[i] cycle loads shadow[i] from byte i and sets seen[i]; all four channels update independently in the same cycle.
REQ-016 SHALL implement FSM states IDLE, LOAD, WR_VAL, WR_CH, DWELL.
REQ-017 IDLE -> LOAD when enable=1; stay in IDLE otherwise.
REQ-018 LOAD (1 cycle): snapshot shadow[cur_ch] and seen[cur_ch] into a display register; -> WR_VAL.
REQ-019 WR_VAL (1 cycle): pio_cs_val=1, pio_write_n=0, pio_writedata[13:7]=seg(high nibble), [6:0]=seg(low nibble); if seen=0, both fields = 7'h3F (dash); -> WR_CH.
REQ-020 WR_CH (1 cycle): pio_cs_ch=1, pio_write_n=0, pio_writedata[13:7]=7'h46 ("C"), [6:0]=seg(cur_ch); -> DWELL with dwell counter loaded to DWELL_CYCLES-1.
REQ-021 DWELL: decrement counter each cycle; at counter 0, if enable=0 -> IDLE, else if freeze=1 -> LOAD with cur_ch unchanged, else cur_ch <= cur_ch+1 (3 wraps to 0) -> LOAD.
REQ-022 In DWELL with counter != 0, ch_valid[cur_ch]=1 SHALL cause refresh: -> LOAD next cycle, saving the counter and resuming it after WR_CH instead of reloading it.
REQ-023 A refresh request coinciding with counter 0 SHALL be ignored; REQ-021 applies (the new LOAD reads the fresh shadow if the channel is unchanged).
REQ-024 enable falling during LOAD/WR_VAL/WR_CH SHALL NOT abort the sequence; it is honoured only at dwell expiry.
REQ-025 Outside WR_VAL/WR_CH: pio_cs_val=0, pio_cs_ch=0, pio_write_n=1, pio_writedata=0; never both chipselects at once.
REQ-026 seg() SHALL be active-low, bit order {g,f,e,d,c,b,a}: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
REQ-027 All outputs SHALL be registered; every write cycle is 1 clk (PIO slaves have no waitrequest).

Reset
REQ-028 reset_n=0 SHALL asynchronously force state IDLE, cur_ch=0, busy=0, dwell counter=0, shadows=0, seen=0, pio_cs_val=0, pio_cs_ch=0, pio_write_n=1, pio_writedata=0, pio_address=0.
REQ-029 Reset asserted mid-write SHALL deassert chipselect immediately; after release, scan restarts from channel 0 via IDLE.

Verification (DWELL_CYCLES=4)
REQ-030 No ch_valid, enable=1 -> cs_val write 0x1FBF (dashes), then cs_ch write 0x2340 ("C0"), next channel LOAD 4 DWELL cycles later.
REQ-031 ch_valid=4'b0010, byte1=0x3A, scan reaches ch1 -> val write 0x1808 ("3A"), ch write 0x2379 ("C1").
REQ-032 Four full dwells with freeze=0 -> cur_ch sequence 0,1,2,3,0 (wrap checked).
REQ-033 freeze=1 at expiry -> cur_ch unchanged, value rewritten; ch_valid[cur_ch] with counter=2 -> refresh writes, then 2 remaining DWELL cycles before next LOAD.
REQ-034 enable dropped in WR_VAL -> WR_CH still issued, full dwell, then IDLE, busy=0, no further writes.
REQ-035 reset_n pulsed during WR_CH -> pio_cs_ch=0 same cycle, all REQ-028 values; after release with enable=1 first write is ch0 dashes.
